// File: rtl/osc_clkgen.sv
// CH-channel programmable clock-enable / divided-clock generator with optional
// reference-frequency monitor (build with OSC_CLKGEN_FREQMON_EN to include it).
module osc_clkgen #(
  parameter int CH      = 4,
  parameter int DW      = 16,
  parameter int DIV_RST = 49,
  parameter int MON_WIN = 1024,
  parameter int MW      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [3:0]    i_wr_ch,
  input  logic [DW-1:0] i_wr_div,
  input  logic          i_wr_on,
  output logic [CH-1:0] o_tick,
  output logic [CH-1:0] o_div_clk,
  output logic [CH-1:0] o_pending,
  input  logic          i_mon_in,
  output logic [MW-1:0] o_mon_count,
  output logic          o_mon_valid
);

  logic [DW-1:0] r_cnt      [CH];
  logic [DW-1:0] r_cur_div  [CH];
  logic [DW-1:0] r_pend_div [CH];
  logic [CH-1:0] r_pending;
  logic [CH-1:0] r_on;
  logic [CH-1:0] r_tick;
  logic [CH-1:0] r_div_clk;
  logic [CH-1:0] w_sel;
  logic [CH-1:0] w_wrap;

  // Write decode and period-boundary detect; indices >= CH never match
  always_comb begin
    w_sel  = {CH{1'b0}};
    w_wrap = {CH{1'b0}};
    for (int c = 0; c < CH; c++) begin
      w_sel[c]  = i_wr_en && (i_wr_ch == 4'(c));
      w_wrap[c] = (r_cnt[c] == r_cur_div[c]);
    end
  end

  // Per-channel divider state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < CH; c++) begin
        r_cnt[c]      <= {DW{1'b0}};
        r_cur_div[c]  <= DW'(DIV_RST);
        r_pend_div[c] <= DW'(DIV_RST);
      end
      r_pending <= {CH{1'b0}};
      r_on      <= {CH{1'b1}};
      r_tick    <= {CH{1'b0}};
      r_div_clk <= {CH{1'b0}};
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_sel[c] && (!i_wr_on || !r_on[c])) begin
          // Stopped channels take the divisor at once and restart from a clean phase
          r_cur_div[c]  <= i_wr_div;
          r_pend_div[c] <= i_wr_div;
          r_pending[c]  <= 1'b0;
          r_on[c]       <= i_wr_on;
          r_cnt[c]      <= {DW{1'b0}};
          r_tick[c]     <= 1'b0;
          r_div_clk[c]  <= 1'b0;
        end else if (r_on[c]) begin
          if (w_wrap[c]) begin
            r_cnt[c]     <= {DW{1'b0}};
            r_tick[c]    <= 1'b1;
            r_div_clk[c] <= ~r_div_clk[c];
            if (r_pending[c]) begin
              r_cur_div[c] <= r_pend_div[c];
            end else begin
              r_cur_div[c] <= r_cur_div[c];
            end
          end else begin
            r_cnt[c]  <= r_cnt[c] + DW'(1);
            r_tick[c] <= 1'b0;
          end
          // A write landing on a wrap is queued behind the value that wrap consumed
          if (w_sel[c]) begin
            r_pend_div[c] <= i_wr_div;
            r_pending[c]  <= 1'b1;
          end else if (w_wrap[c]) begin
            r_pending[c] <= 1'b0;
          end else begin
            r_pending[c] <= r_pending[c];
          end
        end else begin
          r_cnt[c]     <= {DW{1'b0}};
          r_tick[c]    <= 1'b0;
          r_div_clk[c] <= 1'b0;
        end
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_div_clk = r_div_clk;
  assign o_pending = r_pending;

`ifdef OSC_CLKGEN_FREQMON_EN
  localparam int WW = (MON_WIN > 1) ? $clog2(MON_WIN) : 1;

  logic [2:0]    r_sync;
  logic [WW-1:0] r_win;
  logic [MW-1:0] r_edges;
  logic [MW-1:0] r_mon_count;
  logic          r_mon_valid;
  logic          w_rise;
  logic [MW-1:0] w_edges_nxt;

  assign w_rise      = r_sync[1] && !r_sync[2];
  assign w_edges_nxt = (w_rise && (r_edges != {MW{1'b1}})) ? r_edges + MW'(1) : r_edges;

  // Synchroniser, window counter and saturating edge counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 3'b000;
      r_win       <= {WW{1'b0}};
      r_edges     <= {MW{1'b0}};
      r_mon_count <= {MW{1'b0}};
      r_mon_valid <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], i_mon_in};
      if (r_win == WW'(MON_WIN - 1)) begin
        r_win       <= {WW{1'b0}};
        r_edges     <= {MW{1'b0}};
        r_mon_count <= w_edges_nxt;
        r_mon_valid <= 1'b1;
      end else begin
        r_win       <= r_win + WW'(1);
        r_edges     <= w_edges_nxt;
        r_mon_valid <= 1'b0;
      end
    end
  end

  assign o_mon_count = r_mon_count;
  assign o_mon_valid = r_mon_valid;
`else
  logic w_unused_mon_in;

  assign w_unused_mon_in = i_mon_in;
  assign o_mon_count     = {MW{1'b0}};
  assign o_mon_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_osc_clkgen.sv
// Directed self-checking bench for osc_clkgen (default parameters, CH=4, DIV_RST=49).
module tb_osc_clkgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [15:0] wr_div;
  logic        wr_on;
  logic [3:0]  tick;
  logic [3:0]  div_clk;
  logic [3:0]  pending;
  logic        mon_in;
  logic [15:0] mon_count;
  logic        mon_valid;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int mon_ph   = 0;
  bit mon_run  = 1'b0;

  osc_clkgen dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_en    (wr_en),
    .i_wr_ch    (wr_ch),
    .i_wr_div   (wr_div),
    .i_wr_on    (wr_on),
    .o_tick     (tick),
    .o_div_clk  (div_clk),
    .o_pending  (pending),
    .i_mon_in   (mon_in),
    .o_mon_count(mon_count),
    .o_mon_valid(mon_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // One clock edge, then settle; mon_in toggles every 8 edges when enabled
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (mon_run) begin
      mon_ph++;
      if (mon_ph == 8) begin
        mon_ph = 0;
        mon_in = ~mon_in;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic cfg(input logic [3:0] ch, input logic [15:0] d, input logic on);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = d;
    wr_on  = on;
    step();
    wr_en  = 1'b0;
  endtask

  initial begin
    int n1;
    int pulses;
    bit found;
    rst = 1'b1; wr_en = 1'b0; wr_ch = 4'd0; wr_div = 16'd0; wr_on = 1'b0; mon_in = 1'b0;
    repeat (3) step();
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_divclk", 32'(div_clk), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_mon_count", 32'(mon_count), 32'h0);
    check("rst_mon_valid", 32'(mon_valid), 32'h0);
    rst = 1'b0;
    n = 0;

    // First tick at edge 50, period 50; div_clk period 100
    run_to(49);  check("first_tick_early", 32'(tick), 32'h0);
    run_to(50);  check("first_tick", 32'(tick), 32'hF);
                 check("first_divclk", 32'(div_clk), 32'hF);
    run_to(51);  check("tick_one_cycle", 32'(tick), 32'h0);
    run_to(100); check("second_tick", 32'(tick[0]), 32'h1);
                 check("divclk_period", 32'(div_clk[0]), 32'h0);

    // ch1 D=3 written mid-period
    run_to(120); cfg(4'd1, 16'd3, 1'b1);
    check("ch1_pending_set", 32'(pending), 32'h2);
    run_to(149); check("ch1_pending_hold", 32'(pending[1]), 32'h1);
                 check("ch1_no_early_tick", 32'(tick[1]), 32'h0);
    run_to(150); check("ch1_wrap_tick", 32'(tick), 32'hF);
                 check("ch1_pending_clr", 32'(pending[1]), 32'h0);
                 check("wrap_divclk", 32'(div_clk), 32'hF);
    run_to(153); check("ch1_d3_gap", 32'(tick[1]), 32'h0);
    run_to(154); check("ch1_d3_tick", 32'(tick[1]), 32'h1);
                 check("ch1_d3_divclk", 32'(div_clk[1]), 32'h0);

    // ch2 off, then D=0 on
    cfg(4'd2, 16'd7, 1'b0);
    check("ch2_off_tick", 32'(tick[2]), 32'h0);
    check("ch2_off_divclk", 32'(div_clk[2]), 32'h0);
    check("ch2_off_pending", 32'(pending[2]), 32'h0);
    run_to(200); check("ch2_off_hold", 32'({tick[2], div_clk[2]}), 32'h0);
                 check("ch0_during_ch2_off", 32'(tick[0]), 32'h1);
    cfg(4'd2, 16'd0, 1'b1);
    check("ch2_on_first", 32'(tick[2]), 32'h0);
    check("ch2_on_pending", 32'(pending[2]), 32'h0);
    run_to(202); check("ch2_d0_a", 32'({tick[2], div_clk[2]}), 32'h3);
    run_to(203); check("ch2_d0_b", 32'({tick[2], div_clk[2]}), 32'h2);
    run_to(204); check("ch2_d0_c", 32'({tick[2], div_clk[2]}), 32'h3);

    // Writes to ch0 landing on its wrap cycles
    run_to(249); cfg(4'd0, 16'd9, 1'b1);
    check("ch0_wrap_write_tick", 32'(tick[0]), 32'h1);
    check("ch0_wrap_write_pend", 32'(pending[0]), 32'h1);
    run_to(299); check("ch0_old_period", 32'({tick[0], pending[0]}), 32'h1);
    cfg(4'd0, 16'd19, 1'b1);
    check("ch0_second_wrap", 32'({tick[0], pending[0]}), 32'h3);
    run_to(309); check("ch0_d9_gap", 32'(tick[0]), 32'h0);
    run_to(310); check("ch0_d9_tick", 32'({tick[0], pending[0]}), 32'h2);
                 check("ch3_unaffected_a", 32'(tick[3]), 32'h0);
    run_to(329); check("ch0_d19_gap", 32'(tick[0]), 32'h0);
    run_to(330); check("ch0_d19_tick", 32'(tick[0]), 32'h1);
    run_to(350); check("ch0_ch3_align", 32'({tick[3], tick[0]}), 32'h3);

    // Out-of-range channel index
    cfg(4'd5, 16'd2, 1'b0);
    check("badch_pending", 32'(pending), 32'h0);
    check("badch_ch3_divclk", 32'(div_clk[3]), 32'h1);
    check("badch_ch1_divclk", 32'(div_clk[1]), 32'h1);
    run_to(370); check("badch_ch0_runs", 32'(tick[0]), 32'h1);
    run_to(400); check("badch_ch3_runs", 32'(tick[3]), 32'h1);

    // Reset discards an in-flight pending write
    cfg(4'd3, 16'd5, 1'b1);
    check("pre_rst_pending", 32'(pending), 32'h8);
    rst = 1'b1;
    step();
    check("mid_rst_pending", 32'(pending), 32'h0);
    check("mid_rst_outputs", 32'({tick, div_clk}), 32'h0);
    rst = 1'b0;
    n = 0;
    mon_run = 1'b1;
    run_to(49); check("rerst_early", 32'(tick), 32'h0);
    run_to(50); check("rerst_div_rst", 32'(tick), 32'hF);
    run_to(54); check("rerst_ch1_d49", 32'(tick[1]), 32'h0);

`ifdef OSC_CLKGEN_FREQMON_EN
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      step();
      if (mon_valid) found = 1'b1;
    end
    check("mon_first_window", 32'(found), 32'h1);
    check("mon_first_edge", 32'(n), 32'd1024);
    n1 = n;
    step();
    check("mon_valid_pulse", 32'(mon_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      step();
      if (mon_valid) found = 1'b1;
    end
    check("mon_second_window", 32'(found), 32'h1);
    check("mon_window_len", 32'(n - n1), 32'd1024);
    check("mon_count", 32'(mon_count), 32'd64);
`else
    pulses = 0;
    for (int i = 0; i < 2100; i++) begin
      step();
      if (mon_valid) pulses++;
    end
    check("mon_off_valid", 32'(pulses), 32'd0);
    check("mon_off_count", 32'(mon_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
